// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the architectural PC, fetches one word per
// instruction over a req/ack handshake, holds it for decode and traps on faults.
module fetch_pc_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [63:0] NextPC,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    input  logic        InstrTaken,
    output logic [63:0] CurrentPC,
    output logic        IMemReq,
    output logic [63:0] IMemAddr,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic        Fault,
    output logic [1:0]  FaultCause,
    output logic [31:0] InstrCount
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_next;
    logic [63:0] pc_next;
    logic [31:0] instr_next;
    logic [31:0] count_next;
    logic [1:0]  cause_next;

    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        pc_next    = CurrentPC;
        instr_next = Instruction;
        count_next = InstrCount;
        cause_next = FaultCause;
        case (state)
            FETCH: begin
                // The first cycle after reset sits in FETCH with the request still
                // low; the handshake only counts once IMemReq is actually driven.
                if (IMemReq) begin
                    if (IMemAck) begin
                        instr_next = IMemData;
                        wait_next  = 8'd0;
                        state_next = HOLD;
                    end else if (wait_cnt == LAST_WAIT) begin
                        wait_next  = 8'd0;
                        cause_next = 2'b10;
                        state_next = FAULT;
                    end else begin
                        wait_next = wait_cnt + 8'd1;
                    end
                end
            end
            HOLD: begin
                if (InstrTaken) begin
                    count_next = InstrCount + 32'd1;
                    if (NextPC[1:0] == 2'b00) begin
                        pc_next    = NextPC;
                        state_next = FETCH;
                    end else begin
                        cause_next = 2'b01;
                        state_next = FAULT;
                    end
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= FETCH;
            wait_cnt    <= 8'd0;
            CurrentPC   <= RESET_PC;
            Instruction <= 32'd0;
            InstrCount  <= 32'd0;
            FaultCause  <= 2'b00;
            IMemReq     <= 1'b0;
            InstrValid  <= 1'b0;
            Fault       <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_next;
            CurrentPC   <= pc_next;
            Instruction <= instr_next;
            InstrCount  <= count_next;
            FaultCause  <= cause_next;
            IMemReq     <= (state_next == FETCH);
            InstrValid  <= (state_next == HOLD);
            Fault       <= (state_next == FAULT);
        end
    end

    assign IMemAddr = CurrentPC;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit against a transaction-level model of PC,
// retired count and held instruction.
module tb_fetch_pc_unit;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam int          TMO    = 4;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [63:0] NextPC = 64'd0;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemData = 32'd0;
    logic        InstrTaken = 1'b0;
    logic [63:0] CurrentPC;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        Fault;
    logic [1:0]  FaultCause;
    logic [31:0] InstrCount;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_pc;
    logic [31:0] exp_count;

    fetch_pc_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .IMemAck(IMemAck),
        .IMemData(IMemData), .InstrTaken(InstrTaken), .CurrentPC(CurrentPC),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .Instruction(Instruction),
        .InstrValid(InstrValid), .Fault(Fault), .FaultCause(FaultCause),
        .InstrCount(InstrCount)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({IMemReq, InstrValid, Fault} !== 3'b000 || CurrentPC !== RST_PC ||
            Instruction !== 32'd0 || FaultCause !== 2'b00 || InstrCount !== 32'd0) begin
            errors++;
            $display("FAIL %s: req=%b vld=%b fault=%b pc=%h instr=%h cause=%b cnt=%0d, want all zero/pc=%h",
                     tag, IMemReq, InstrValid, Fault, CurrentPC, Instruction, FaultCause, InstrCount, RST_PC);
        end
    endtask

    // Leaves the bench in the first requesting cycle after reset.
    task automatic apply_reset();
        Reset = 1'b1; IMemAck = 1'b0; InstrTaken = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        exp_pc = RST_PC;
        exp_count = 32'd0;
    endtask

    // One full instruction: w wait cycles, hold cycles without retire, then retire with np.
    task automatic fetch_one(input int w, input logic [31:0] data, input logic [63:0] np, input int hold);
        logic [1:0] low;
        for (int i = 0; i < w; i++) begin
            checks++;
            if (IMemReq !== 1'b1 || IMemAddr !== exp_pc || InstrValid !== 1'b0) begin
                errors++;
                $display("FAIL wait_req: req=%b addr=%h vld=%b, want req=1 addr=%h vld=0",
                         IMemReq, IMemAddr, InstrValid, exp_pc);
            end
            IMemData = $urandom;
            tick();
        end
        checks++;
        if (IMemReq !== 1'b1 || CurrentPC !== exp_pc || IMemAddr !== exp_pc) begin
            errors++;
            $display("FAIL ack_req: req=%b pc=%h addr=%h, want req=1 pc=%h", IMemReq, CurrentPC, IMemAddr, exp_pc);
        end
        IMemAck = 1'b1; IMemData = data;
        tick();
        IMemAck = 1'b0;
        checks++;
        if (InstrValid !== 1'b1 || Instruction !== data || IMemReq !== 1'b0 || InstrCount !== exp_count) begin
            errors++;
            $display("FAIL hold_entry: vld=%b instr=%h req=%b cnt=%0d, want vld=1 instr=%h req=0 cnt=%0d",
                     InstrValid, Instruction, IMemReq, InstrCount, data, exp_count);
        end
        for (int i = 0; i < hold; i++) begin
            IMemAck = 1'($urandom); IMemData = $urandom; NextPC = {$urandom, $urandom};
            tick();
            checks++;
            if (InstrValid !== 1'b1 || Instruction !== data || CurrentPC !== exp_pc || IMemReq !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: vld=%b instr=%h pc=%h req=%b, want vld=1 instr=%h pc=%h req=0",
                         InstrValid, Instruction, CurrentPC, IMemReq, data, exp_pc);
            end
        end
        IMemAck = 1'b0; NextPC = np; InstrTaken = 1'b1;
        tick();
        InstrTaken = 1'b0;
        exp_count = exp_count + 32'd1;
        low = np[1:0];
        checks++;
        if (low == 2'b00) begin
            exp_pc = np;
            if (IMemReq !== 1'b1 || InstrValid !== 1'b0 || CurrentPC !== exp_pc ||
                InstrCount !== exp_count || Fault !== 1'b0) begin
                errors++;
                $display("FAIL retire: req=%b vld=%b pc=%h cnt=%0d fault=%b, want req=1 vld=0 pc=%h cnt=%0d fault=0",
                         IMemReq, InstrValid, CurrentPC, InstrCount, Fault, exp_pc, exp_count);
            end
        end else begin
            if (Fault !== 1'b1 || FaultCause !== 2'b01 || IMemReq !== 1'b0 || InstrValid !== 1'b0 ||
                CurrentPC !== exp_pc || InstrCount !== exp_count) begin
                errors++;
                $display("FAIL misalign: fault=%b cause=%b req=%b vld=%b pc=%h cnt=%0d, want 1/01/0/0 pc=%h cnt=%0d",
                         Fault, FaultCause, IMemReq, InstrValid, CurrentPC, InstrCount, exp_pc, exp_count);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_values("reset_held");
        end
        Reset = 1'b0;
        tick();
        exp_pc = RST_PC; exp_count = 32'd0;
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== RST_PC || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h vld=%b, want req=1 addr=%h vld=0", IMemReq, IMemAddr, InstrValid, RST_PC);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) fetch_one(0, 32'h8B020020, exp_pc + 64'd4, 0);
        checks++;
        if (InstrCount !== 32'd3 || CurrentPC !== 64'hC) begin
            errors++;
            $display("FAIL seq_count: cnt=%0d pc=%h, want cnt=3 pc=c", InstrCount, CurrentPC);
        end
    endtask

    task automatic test_wait_states();
        fetch_one(3, 32'hA5A5_0F0F, exp_pc + 64'd4, 10);
        fetch_one(TMO - 1, 32'h1234_5678, exp_pc + 64'd4, 0);
    endtask

    task automatic test_branch();
        fetch_one(0, $urandom, 64'h1000, 1);
        fetch_one(1, $urandom, 64'hFFC, 0);
        checks++;
        if (CurrentPC !== 64'hFFC) begin
            errors++;
            $display("FAIL branch_pc: pc=%h, want ffc", CurrentPC);
        end
    endtask

    task automatic test_random();
        logic [63:0] np;
        for (int n = 0; n < 20; n++) begin
            np = {$urandom, $urandom};
            np[1:0] = 2'b00;
            fetch_one($urandom_range(0, TMO - 1), $urandom, np, $urandom_range(0, 2));
        end
    endtask

    task automatic test_misaligned();
        logic [63:0] held_pc;
        logic [31:0] held_cnt;
        logic [31:0] held_instr;
        fetch_one(1, 32'hCAFE_F00D, 64'h1002, 0);
        held_pc = exp_pc; held_cnt = exp_count; held_instr = 32'hCAFE_F00D;
        for (int i = 0; i < 5; i++) begin
            IMemAck = 1'b1; InstrTaken = 1'b1; NextPC = 64'h2000; IMemData = $urandom;
            tick();
            checks++;
            if (Fault !== 1'b1 || FaultCause !== 2'b01 || IMemReq !== 1'b0 || CurrentPC !== held_pc ||
                InstrCount !== held_cnt || Instruction !== held_instr) begin
                errors++;
                $display("FAIL fault_frozen: fault=%b cause=%b req=%b pc=%h cnt=%0d instr=%h, want 1/01/0 pc=%h cnt=%0d instr=%h",
                         Fault, FaultCause, IMemReq, CurrentPC, InstrCount, Instruction, held_pc, held_cnt, held_instr);
            end
        end
        Reset = 1'b1; IMemAck = 1'b0; InstrTaken = 1'b0;
        tick();
        check_reset_values("fault_reset");
        Reset = 1'b0;
        tick();
        exp_pc = RST_PC; exp_count = 32'd0;
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== RST_PC || Fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_release: req=%b addr=%h fault=%b, want req=1 addr=%h fault=0", IMemReq, IMemAddr, Fault, RST_PC);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < TMO; i++) begin
            checks++;
            if (IMemReq !== 1'b1 || Fault !== 1'b0) begin
                errors++;
                $display("FAIL timeout_req: cycle=%0d req=%b fault=%b, want req=1 fault=0", i, IMemReq, Fault);
            end
            tick();
        end
        checks++;
        if (Fault !== 1'b1 || FaultCause !== 2'b10 || IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: fault=%b cause=%b req=%b vld=%b, want 1/10/0/0", Fault, FaultCause, IMemReq, InstrValid);
        end
        for (int i = 0; i < 3; i++) begin
            IMemAck = 1'b1; IMemData = 32'hFFFF_0000; InstrTaken = 1'b1;
            tick();
            checks++;
            if (Fault !== 1'b1 || FaultCause !== 2'b10 || IMemReq !== 1'b0 || InstrValid !== 1'b0 ||
                Instruction !== 32'd0 || CurrentPC !== RST_PC || InstrCount !== 32'd0) begin
                errors++;
                $display("FAIL timeout_spurious: fault=%b cause=%b req=%b vld=%b instr=%h pc=%h cnt=%0d, want 1/10/0/0/0/%h/0",
                         Fault, FaultCause, IMemReq, InstrValid, Instruction, CurrentPC, InstrCount, RST_PC);
            end
        end
        apply_reset();
    endtask

    task automatic test_reset_on_ack();
        IMemAck = 1'b1; IMemData = 32'hDEAD_BEEF; Reset = 1'b1;
        tick();
        Reset = 1'b0; IMemAck = 1'b0;
        check_reset_values("reset_on_ack");
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (IMemReq !== 1'b1 || InstrValid !== 1'b0 || Instruction !== 32'd0) begin
                errors++;
                $display("FAIL ack_discarded: req=%b vld=%b instr=%h, want req=1 vld=0 instr=0", IMemReq, InstrValid, Instruction);
            end
        end
        exp_pc = RST_PC; exp_count = 32'd0;
        fetch_one(0, 32'h0BAD_F00D, 64'h40, 0);
    endtask

    task automatic test_reset_mid_hold();
        IMemAck = 1'b1; IMemData = 32'h7777_7777;
        tick();
        IMemAck = 1'b0; Reset = 1'b1; InstrTaken = 1'b1; NextPC = 64'h80;
        tick();
        Reset = 1'b0; InstrTaken = 1'b0;
        check_reset_values("reset_mid_hold");
    endtask

    initial begin
        exp_pc = RST_PC;
        exp_count = 32'd0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_branch();
        test_random();
        test_misaligned();
        test_timeout();
        test_reset_on_ack();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
